mem_loader_sel0628: RTL and testbench

- Memory-side responder for the SEL0628 8-bit processor bus: 64x8 RAM with combinational read and synchronous write, plus two memory-mapped I/O ports.
- Includes a byte-stream program loader with a valid/ready handshake.
- While a program is loading, the loader holds the processor in reset through a registered reset output, then releases it.
- Sits between the processor's addr/we/data_out/data_in pins and the board-level host/IO.

---
 rtl/mem_loader_sel0628_pkg.sv | 19 +
 rtl/mem_loader_sel0628_ram64x8.sv | 24 ++
 rtl/mem_loader_sel0628.sv | 122 ++++++++++++
 tb/tb_mem_loader_sel0628.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_sel0628_pkg.sv
// Shared types and constants for the SEL0628 memory-side responder.
// Holds the loader state encoding, bus widths and the default I/O port addresses.
package mem_loader_sel0628_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  localparam logic [ADDR_W-1:0] DEF_IN_ADDR  = 6'd62;
  localparam logic [ADDR_W-1:0] DEF_OUT_ADDR = 6'd63;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_loader_sel0628_ram64x8.sv
// 64x8 RAM: combinational read, single synchronous write port.
// Contents are deliberately not reset so a partial program survives clr_n.
module ram64x8
  import mem_loader_sel0628_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_loader_sel0628.sv
// SEL0628 memory responder: RAM plus GPIO ports, and a byte-stream program
// loader that holds the processor in reset while a program is written.
module mem_loader_sel0628
  import mem_loader_sel0628_pkg::*;
#(
  parameter int                LOAD_LEN = 64,
  parameter logic [ADDR_W-1:0] IN_ADDR  = DEF_IN_ADDR,
  parameter logic [ADDR_W-1:0] OUT_ADDR = DEF_OUT_ADDR
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] cpu_addr,
  input  logic       cpu_we,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rst_n,
  input  logic       ld_start,
  input  logic       go,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_done,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] gpio_out_q, gpio_out_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;

  logic              ld_accept;
  logic              cpu_wr_ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // A restart pulse in LOAD takes priority, so a byte offered alongside it is dropped.
  assign ld_accept = (state_q == ST_LOAD) && ld_valid && !ld_start;
  assign cpu_wr_ok = (state_q == ST_RUN) && cpu_we;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_HOLD;
      ptr_q       <= '0;
      gpio_out_q  <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gpio_out_q  <= gpio_out_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (ld_start)  state_d = ST_LOAD;
        else if (go)   state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (ld_accept && (ptr_q == LAST_PTR)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_RUN;
      ST_RUN: begin
        if (ld_start)  state_d = ST_LOAD;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ld_start && (state_q != ST_DONE)) begin
      ptr_d = '0;
    end else if (ld_accept) begin
      ptr_d = ptr_q + 1'b1;
    end

    gpio_out_d = gpio_out_q;
    if (cpu_wr_ok && (cpu_addr == OUT_ADDR)) begin
      gpio_out_d = cpu_wdata;
    end

    // Registered from the next state so release and re-assertion line up with the state change.
    cpu_rst_n_d = (state_d == ST_RUN);
  end

  always_comb begin
    ld_ready = (state_q == ST_LOAD);
    ld_done  = (state_q == ST_DONE);
  end

  assign ram_we    = ld_accept ||
                     (cpu_wr_ok && (cpu_addr != IN_ADDR) && (cpu_addr != OUT_ADDR));
  assign ram_waddr = (state_q == ST_LOAD) ? ptr_q   : cpu_addr;
  assign ram_wdata = (state_q == ST_LOAD) ? ld_data : cpu_wdata;

  ram64x8 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cpu_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    if (cpu_addr == IN_ADDR)       cpu_rdata = gpio_in;
    else if (cpu_addr == OUT_ADDR) cpu_rdata = gpio_out_q;
    else                           cpu_rdata = ram_rdata;
  end

  assign cpu_rst_n = cpu_rst_n_q;
  assign gpio_out  = gpio_out_q;

endmodule

// File: tb/tb_mem_loader_sel0628.sv
// Scoreboard bench for mem_loader_sel0628: stimulus queues expectations,
// a negedge monitor pops and compares them, and tracks ld_done pulse timing.
module tb_mem_loader_sel0628;

  typedef struct {
    string      name;
    int         id;
    logic [7:0] exp;
  } chk_t;

  logic       clk;
  logic       clr_n;
  logic [5:0] cpu_addr;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_rst_n;
  logic       ld_start;
  logic       go;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;

  logic [5:0] b_cpu_addr;
  logic [7:0] b_cpu_rdata;
  logic       b_cpu_rst_n;
  logic       b_ld_start;
  logic       b_ld_valid;
  logic [7:0] b_ld_data;
  logic       b_ld_ready;
  logic       b_ld_done;
  logic [7:0] b_gpio_out;
  logic       zero1;
  logic [7:0] zero8;

  chk_t chk_q[$];
  int   done_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic end_req;
  logic end_ack;

  mem_loader_sel0628 u_dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rst_n (cpu_rst_n),
    .ld_start  (ld_start),
    .go        (go),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  mem_loader_sel0628 #(.LOAD_LEN(4)) u_dut4 (
    .clk       (clk),
    .clr_n     (clr_n),
    .cpu_addr  (b_cpu_addr),
    .cpu_we    (zero1),
    .cpu_wdata (zero8),
    .cpu_rdata (b_cpu_rdata),
    .cpu_rst_n (b_cpu_rst_n),
    .ld_start  (b_ld_start),
    .go        (zero1),
    .ld_valid  (b_ld_valid),
    .ld_data   (b_ld_data),
    .ld_ready  (b_ld_ready),
    .ld_done   (b_ld_done),
    .gpio_in   (zero8),
    .gpio_out  (b_gpio_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    end_ack = 1'b0;
  end

  always @(negedge clk) begin
    logic [7:0] act;
    chk_t c;
    int e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.id)
        0:       act = cpu_rdata;
        1:       act = {7'd0, cpu_rst_n};
        2:       act = gpio_out;
        3:       act = {7'd0, ld_ready};
        4:       act = {7'd0, ld_done};
        5:       act = b_cpu_rdata;
        6:       act = u_dut.u_ram.mem_q[63];
        7:       act = u_dut.u_ram.mem_q[62];
        8:       act = {7'd0, b_ld_done};
        default: act = {7'd0, b_ld_ready};
      endcase
      n_cmp = n_cmp + 1;
      if (act !== c.exp) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %h want %h (cycle %0d)", c.name, act, c.exp, cyc);
      end else begin
        $display("check %s: got %h ok (cycle %0d)", c.name, act, cyc);
      end
    end
    if (ld_done === 1'b1) begin
      n_cmp = n_cmp + 1;
      if (done_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL ld_done_pulse: got pulse at cycle %0d want none", cyc);
      end else begin
        e = done_q.pop_front();
        if (e != cyc) begin
          n_err = n_err + 1;
          $display("FAIL ld_done_pulse: got cycle %0d want cycle %0d", cyc, e);
        end else begin
          $display("check ld_done_pulse: cycle %0d ok", cyc);
        end
      end
    end
    if (end_req && !end_ack) begin
      n_cmp = n_cmp + 1;
      if (done_q.size() != 0) begin
        n_err = n_err + 1;
        $display("FAIL ld_done_missing: got %0d pulses outstanding want 0", done_q.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input int id, input logic [7:0] exp);
    chk_q.push_back('{name, id, exp});
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string name);
    cpu_addr = a;
    expect_val(name, 0, exp);
    tick();
  endtask

  task automatic rd_b(input logic [5:0] a, input logic [7:0] exp, input string name);
    b_cpu_addr = a;
    expect_val(name, 5, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b4 [4];
    b4[0] = 8'hA1; b4[1] = 8'hB2; b4[2] = 8'hC3; b4[3] = 8'hD4;
    end_req = 1'b0;
    clr_n = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    ld_start = 1'b0; go = 1'b0; ld_valid = 1'b0; ld_data = '0; gpio_in = '0;
    b_cpu_addr = '0; b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0;
    zero1 = 1'b0; zero8 = '0;

    tick();
    expect_val("rst_cpu_rst_n", 1, 8'h00);
    expect_val("rst_gpio_out",  2, 8'h00);
    expect_val("rst_ld_ready",  3, 8'h00);
    expect_val("rst_ld_done",   4, 8'h00);
    tick();
    clr_n = 1'b1;
    tick();

    // go without loading
    go = 1'b1;
    expect_val("go_still_reset", 1, 8'h00);
    tick();
    go = 1'b0;
    expect_val("go_released", 1, 8'h01);
    expect_val("go_gpio_zero", 2, 8'h00);
    tick();

    // full 64-byte load from RUN
    ld_start = 1'b1;
    expect_val("ld_start_edge_pre", 1, 8'h01);
    tick();
    ld_start = 1'b0;
    expect_val("load_rst_low", 1, 8'h00);
    expect_val("load_ready",   3, 8'h01);
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      if (i == 63) done_q.push_back(cyc + 1);
      tick();
    end
    ld_valid = 1'b0;
    expect_val("done_pulse",    4, 8'h01);
    expect_val("done_not_ready", 3, 8'h00);
    expect_val("done_rst_low",  1, 8'h00);
    tick();
    expect_val("run_after_done", 1, 8'h01);
    rd(6'd10, 8'h0A, "rd_addr10");
    rd(6'd40, 8'h28, "rd_addr40");

    // RUN-mode processor accesses
    cpu_addr = 6'd63; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    expect_val("gpio_out_5a",   2, 8'h5A);
    expect_val("mem63_kept",    6, 8'h3F);
    expect_val("rd_out_port",   0, 8'h5A);
    tick();
    cpu_addr = 6'd62; gpio_in = 8'hC3; cpu_wdata = 8'h11; cpu_we = 1'b1;
    expect_val("rd_in_port", 0, 8'hC3);
    tick();
    cpu_we = 1'b0;
    expect_val("mem62_kept", 7, 8'h3E);
    tick();
    cpu_addr = 6'd5; cpu_wdata = 8'h77; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    rd(6'd5, 8'h77, "rd_addr5_written");

    // reload with mid-load restart and ignored processor writes
    ld_start = 1'b1;
    expect_val("reload_pre", 1, 8'h01);
    tick();
    ld_start = 1'b0;
    expect_val("reload_rst_low", 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 8'h11 * 8'(i + 1);
      tick();
    end
    ld_start = 1'b1; ld_data = 8'h99;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h80 + 8'(i);
      cpu_we   = (i > 20 && i < 40);
      cpu_addr = 6'd20; cpu_wdata = 8'hEE;
      if (i == 63) done_q.push_back(cyc + 1);
      tick();
    end
    ld_valid = 1'b0; cpu_we = 1'b0;
    expect_val("reload_done", 4, 8'h01);
    tick();
    expect_val("reload_run", 1, 8'h01);
    rd(6'd0,  8'h80, "reload_addr0");
    rd(6'd1,  8'h81, "reload_addr1");
    rd(6'd20, 8'h94, "reload_addr20_no_cpu_wr");
    rd(6'd63, 8'h5A, "gpio_unaffected_by_load");

    // clr_n in the middle of a load
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_data = 8'h40 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    clr_n = 1'b0;
    expect_val("clr_ready_low", 3, 8'h00);
    expect_val("clr_rst_low",   1, 8'h00);
    expect_val("clr_gpio_zero", 2, 8'h00);
    tick();
    clr_n = 1'b1;
    rd(6'd9,  8'h49, "clr_kept_addr9");
    rd(6'd10, 8'h8A, "clr_old_addr10");
    expect_val("clr_hold_rst", 1, 8'h00);
    go = 1'b1;
    tick();
    go = 1'b0;
    expect_val("clr_go_release", 1, 8'h01);
    tick();

    // LOAD_LEN=4 instance with valid toggling every other cycle
    b_ld_start = 1'b1;
    tick();
    b_ld_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_ld_valid = (i % 2 == 0);
      b_ld_data  = (i % 2 == 0) ? b4[i / 2] : 8'h5E;
      if (i == 1) expect_val("b_ready_in_load", 9, 8'h01);
      if (i == 7) begin
        expect_val("b_done_pulse", 8, 8'h01);
        expect_val("b_done_not_ready", 9, 8'h00);
      end
      tick();
    end
    b_ld_valid = 1'b0;
    rd_b(6'd0, 8'hA1, "b_addr0");
    rd_b(6'd1, 8'hB2, "b_addr1");
    rd_b(6'd2, 8'hC3, "b_addr2");
    rd_b(6'd3, 8'hD4, "b_addr3");

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_ack; k++) tick();
    if (!end_ack) begin
      $display("FAIL end_handshake: got no ack want ack");
      $fatal(1, "monitor did not acknowledge end");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
